// File: rtl/regfile_rdmux.sv
// Register file with one write port and NUM_RD independent read ports.
// Each read port selects one of DEPTH registers. It supports an optional
// hardwired-zero R0, write-through bypass, zero data for out-of-range
// indices and an optional registered read stage with a per-port valid.
module regfile_rdmux #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned READ_REG = 0,
    localparam int unsigned SELW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [SELW-1:0]          wsel,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*SELW-1:0]   rsel,
    output logic [NUM_RD*WIDTH-1:0]  rdata,
    output logic [NUM_RD-1:0]        rvalid
);

    localparam bit ZeroEn = (ZERO_REG != 0);
    // DEPTH extended by one bit so it can be compared against a SELW-bit index.
    localparam logic [SELW:0] DepthExt = (SELW + 1)'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wr_ok;
    logic [SELW-1:0]  rd_sel [NUM_RD];
    logic [WIDTH-1:0] rd_val [NUM_RD];

    // Decide whether the current write really lands in a register.
    always_comb begin
        wr_ok = we;
        if ({1'b0, wsel} >= DepthExt) begin
            wr_ok = 1'b0;
        end
        if (ZeroEn && (wsel == '0)) begin
            wr_ok = 1'b0;
        end
    end

    // Next-state of the storage array.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (wsel == SELW'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    // Storage registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rsel
        assign rd_sel[p] = rsel[p*SELW +: SELW];
    end

    // Per-port selector. Indices that match no register fall through to zero.
    // Bypass is qualified by wr_ok, so it never applies to out-of-range or
    // hardwired-zero targets.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_val[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_sel[p] == SELW'(i)) begin
                    rd_val[p] = regs_q[i];
                end
            end
            if (ZeroEn && (rd_sel[p] == '0)) begin
                rd_val[p] = '0;
            end
            if (wr_ok && (wsel == rd_sel[p])) begin
                rd_val[p] = wdata;
            end
        end
    end

    if (READ_REG == 0) begin : g_comb_read
        // rd_en has no effect on a combinational read port.
        logic unused_rd_en;
        assign unused_rd_en = ^rd_en;

        // Combinational outputs, forced to zero while in reset.
        always_comb begin
            for (int p = 0; p < NUM_RD; p++) begin
                rdata[p*WIDTH +: WIDTH] = rst_n ? rd_val[p] : '0;
                rvalid[p]               = rst_n;
            end
        end
    end else begin : g_reg_read
        logic [WIDTH-1:0]  rdata_q [NUM_RD];
        logic [WIDTH-1:0]  rdata_d [NUM_RD];
        logic [NUM_RD-1:0] rvalid_q;
        logic [NUM_RD-1:0] rvalid_d;

        // Capture on rd_en, otherwise hold data and drop valid.
        always_comb begin
            for (int p = 0; p < NUM_RD; p++) begin
                rdata_d[p]  = rdata_q[p];
                rvalid_d[p] = 1'b0;
                if (rd_en[p]) begin
                    rdata_d[p]  = rd_val[p];
                    rvalid_d[p] = 1'b1;
                end
            end
        end

        // Read stage registers, cleared asynchronously.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int p = 0; p < NUM_RD; p++) begin
                    rdata_q[p] <= '0;
                end
                rvalid_q <= '0;
            end else begin
                for (int p = 0; p < NUM_RD; p++) begin
                    rdata_q[p] <= rdata_d[p];
                end
                rvalid_q <= rvalid_d;
            end
        end

        // Flatten the read stage onto the output bus.
        always_comb begin
            for (int p = 0; p < NUM_RD; p++) begin
                rdata[p*WIDTH +: WIDTH] = rdata_q[p];
            end
            rvalid = rvalid_q;
        end
    end

endmodule

// File: tb/tb_regfile_rdmux.sv
// Self-checking bench for regfile_rdmux. It drives three configurations from
// shared stimulus:
//   A: DEPTH=12, ZERO_REG=1, combinational read
//   B: DEPTH=16, ZERO_REG=0, registered read
//   C: DEPTH=12, ZERO_REG=1, registered read
module tb_regfile_rdmux;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  wsel;
    logic [31:0] wdata;
    logic [1:0]  rd_en;
    logic [7:0]  rsel;

    logic [63:0] rdata_a, rdata_b, rdata_c;
    logic [1:0]  rvalid_a, rvalid_b, rvalid_c;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_rdmux #(.WIDTH(32), .DEPTH(12), .NUM_RD(2), .ZERO_REG(1), .READ_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata),
        .rd_en(rd_en), .rsel(rsel), .rdata(rdata_a), .rvalid(rvalid_a)
    );
    regfile_rdmux #(.WIDTH(32), .DEPTH(16), .NUM_RD(2), .ZERO_REG(0), .READ_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata),
        .rd_en(rd_en), .rsel(rsel), .rdata(rdata_b), .rvalid(rvalid_b)
    );
    regfile_rdmux #(.WIDTH(32), .DEPTH(12), .NUM_RD(2), .ZERO_REG(1), .READ_REG(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata),
        .rd_en(rd_en), .rsel(rsel), .rdata(rdata_c), .rvalid(rvalid_c)
    );

    always #5 clk = ~clk;

    // Configuration table for the model.
    function automatic int cfg_depth(input int c);
        return (c == 1) ? 16 : 12;
    endfunction
    function automatic bit cfg_zero(input int c);
        return (c != 1);
    endfunction
    function automatic bit cfg_reg(input int c);
        return (c != 0);
    endfunction

    // Reference model: architectural register contents and expected
    // registered read outputs.
    logic [31:0] mem    [3][16];
    logic [31:0] exp_rd [3][2];
    logic        exp_rv [3][2];

    function automatic bit wr_takes(input int c);
        return we && (int'(wsel) < cfg_depth(c)) && !(cfg_zero(c) && wsel == 4'd0);
    endfunction

    function automatic logic [31:0] model_val(input int c, input logic [3:0] s);
        if (int'(s) >= cfg_depth(c)) return 32'h0;
        if (cfg_zero(c) && s == 4'd0) return 32'h0;
        if (wr_takes(c) && wsel == s) return wdata;
        return mem[c][s];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < 16; i++) mem[c][i] <= 32'h0;
                for (int p = 0; p < 2; p++) begin
                    exp_rd[c][p] <= 32'h0;
                    exp_rv[c][p] <= 1'b0;
                end
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (wr_takes(c)) mem[c][wsel] <= wdata;
                for (int p = 0; p < 2; p++) begin
                    if (rd_en[p]) begin
                        exp_rd[c][p] <= model_val(c, rsel[p*4 +: 4]);
                        exp_rv[c][p] <= 1'b1;
                    end else begin
                        exp_rv[c][p] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_rdata(input int c);
        case (c)
            0:       return rdata_a;
            1:       return rdata_b;
            default: return rdata_c;
        endcase
    endfunction
    function automatic logic [1:0] dut_rvalid(input int c);
        case (c)
            0:       return rvalid_a;
            1:       return rvalid_b;
            default: return rvalid_c;
        endcase
    endfunction

    // Compare every configuration against the model on each falling edge.
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 2; p++) begin
                logic [31:0] ed;
                logic        ev;
                logic [63:0] ad;
                logic [1:0]  av;
                if (cfg_reg(c)) begin
                    ed = exp_rd[c][p];
                    ev = exp_rv[c][p];
                end else begin
                    ed = rst_n ? model_val(c, rsel[p*4 +: 4]) : 32'h0;
                    ev = rst_n;
                end
                ad = dut_rdata(c);
                av = dut_rvalid(c);
                check($sformatf("model cfg%0d port%0d rdata", c, p), {32'h0, ad[p*32 +: 32]},
                      {32'h0, ed});
                check($sformatf("model cfg%0d port%0d rvalid", c, p), {63'h0, av[p]},
                      {63'h0, ev});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected contents of the 12-entry configurations after the directed writes.
    function automatic logic [31:0] lit_exp(input int i);
        case (i)
            5:       return 32'h12345678;
            7:       return 32'hA5A5A5A5;
            default: return 32'h0;
        endcase
    endfunction

    typedef struct packed {
        logic        we;
        logic [3:0]  wsel;
        logic [31:0] wdata;
        logic [1:0]  rd_en;
        logic [7:0]  rsel;
    } vec_t;

    vec_t vecs [8] = '{
        '{1'b1, 4'd11, 32'hCAFE0011, 2'b11, {4'd11, 4'd11}},
        '{1'b1, 4'd12, 32'h0BAD0012, 2'b10, {4'd12, 4'd11}},
        '{1'b0, 4'd0,  32'h00000000, 2'b11, {4'd12, 4'd11}},
        '{1'b1, 4'd0,  32'h000000AA, 2'b01, {4'd5,  4'd0}},
        '{1'b1, 4'd15, 32'hF00DF00D, 2'b11, {4'd15, 4'd7}},
        '{1'b0, 4'd0,  32'h00000000, 2'b00, {4'd15, 4'd15}},
        '{1'b1, 4'd5,  32'h5555AAAA, 2'b11, {4'd5,  4'd5}},
        '{1'b0, 4'd0,  32'h00000000, 2'b11, {4'd2,  4'd5}}
    };

    initial begin
        clk   = 1'b0;
        rst_n = 1'b1;
        we    = 1'b0;
        wsel  = 4'd0;
        wdata = 32'h0;
        rd_en = 2'b00;
        rsel  = 8'h0;
        #1 rst_n = 1'b0;
        #2;
        check("reset rdata_a", rdata_a, 64'h0);
        check("reset rvalid_a", {62'h0, rvalid_a}, 64'h0);
        check("reset rdata_b", rdata_b, 64'h0);
        check("reset rvalid_b", {62'h0, rvalid_b}, 64'h0);
        check("reset rdata_c", rdata_c, 64'h0);
        check("reset rvalid_c", {62'h0, rvalid_c}, 64'h0);

        @(negedge clk);
        #2 rst_n = 1'b1;

        // reg3 = DEADBEEF, then reset in mid-cycle
        we = 1'b1; wsel = 4'd3; wdata = 32'hDEADBEEF; rd_en = 2'b11; rsel = {4'd3, 4'd3};
        tick();
        we = 1'b0;
        #0;
        check("reg3 comb read", rdata_a, {32'hDEADBEEF, 32'hDEADBEEF});
        check("reg3 bypass reg read", rdata_b, {32'hDEADBEEF, 32'hDEADBEEF});
        check("reg3 rvalid", {62'h0, rvalid_b}, 64'h3);
        #2 rst_n = 1'b0;
        #1;
        check("midcycle reset rdata_a", rdata_a, 64'h0);
        check("midcycle reset rvalid_a", {62'h0, rvalid_a}, 64'h0);
        check("midcycle reset rdata_b", rdata_b, 64'h0);
        check("midcycle reset rvalid_b", {62'h0, rvalid_b}, 64'h0);
        #2 rst_n = 1'b1;
        #1;
        check("reg3 after reset comb", rdata_a, 64'h0);
        tick();
        check("reg3 after reset reg", rdata_b, 64'h0);
        check("first read after reset rvalid", {62'h0, rvalid_b}, 64'h3);

        // Write then read
        we = 1'b1; wsel = 4'd5; wdata = 32'h12345678; rd_en = 2'b00;
        tick();
        we = 1'b0; rsel = {4'd0, 4'd5}; rd_en = 2'b11;
        #1;
        check("reg5/reg0 comb", rdata_a, {32'h0, 32'h12345678});
        tick();
        check("reg5/reg0 reg B", rdata_b, {32'h0, 32'h12345678});
        check("reg5/reg0 reg C", rdata_c, {32'h0, 32'h12345678});

        // R0 write
        we = 1'b1; wsel = 4'd0; wdata = 32'hFFFFFFFF; rd_en = 2'b00; rsel = 8'h0;
        tick();
        we = 1'b0; rd_en = 2'b11;
        #1;
        check("r0 discarded comb", rdata_a, 64'h0);
        tick();
        check("r0 stored no-zero cfg", rdata_b, {32'hFFFFFFFF, 32'hFFFFFFFF});
        check("r0 discarded reg", rdata_c, 64'h0);

        // Same-cycle bypass on both ports
        we = 1'b1; wsel = 4'd7; wdata = 32'hA5A5A5A5; rsel = {4'd7, 4'd7}; rd_en = 2'b11;
        #1;
        check("bypass comb", rdata_a, {32'hA5A5A5A5, 32'hA5A5A5A5});
        tick();
        we = 1'b0;
        check("bypass reg B", rdata_b, {32'hA5A5A5A5, 32'hA5A5A5A5});
        check("bypass rvalid B", {62'h0, rvalid_b}, 64'h3);
        check("bypass reg C", rdata_c, {32'hA5A5A5A5, 32'hA5A5A5A5});
        check("bypass rvalid C", {62'h0, rvalid_c}, 64'h3);

        // Out-of-range accesses
        we = 1'b1; wsel = 4'd13; wdata = 32'h99; rsel = {4'd13, 4'd13}; rd_en = 2'b11;
        #1;
        check("oor read comb", rdata_a, 64'h0);
        tick();
        check("oor read reg", rdata_c, 64'h0);
        check("idx13 bypass depth16", rdata_b, {32'h99, 32'h99});
        we = 1'b1; wsel = 4'd14; wdata = 32'h55; rd_en = 2'b00;
        tick();
        we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rsel = {i[3:0], i[3:0]}; rd_en = 2'b11;
            #1;
            check($sformatf("scan comb reg%0d", i), rdata_a, {lit_exp(i), lit_exp(i)});
            tick();
            check($sformatf("scan reg reg%0d", i), rdata_c, {lit_exp(i), lit_exp(i)});
        end
        rsel = {4'd14, 4'd13}; rd_en = 2'b11;
        tick();
        check("depth16 reg14/reg13", rdata_b, {32'h55, 32'h99});

        // Registered-read handshake
        we = 1'b1; wsel = 4'd2; wdata = 32'h77; rd_en = 2'b00;
        tick();
        we = 1'b0; rsel = {4'd0, 4'd2}; rd_en = 2'b01;
        tick();
        rd_en = 2'b00;
        check("handshake data B", {32'h0, rdata_b[31:0]}, 64'h77);
        check("handshake valid B", {62'h0, rvalid_b}, 64'h1);
        check("handshake data C", {32'h0, rdata_c[31:0]}, 64'h77);
        tick();
        check("handshake valid drop", {62'h0, rvalid_b}, 64'h0);
        check("handshake data hold", {32'h0, rdata_b[31:0]}, 64'h77);

        // Further directed vectors, checked by the model only.
        for (int v = 0; v < 8; v++) begin
            we = vecs[v].we; wsel = vecs[v].wsel; wdata = vecs[v].wdata;
            rd_en = vecs[v].rd_en; rsel = vecs[v].rsel;
            tick();
        end
        we = 1'b0; rd_en = 2'b11; rsel = {4'd11, 4'd12};
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
